// File: rtl/loop_addr_gen.sv
// rtl/loop_addr_gen.sv - index tuple to row-major A/B/C address pipeline
// Multiply stage then add stage, with range check, beat/error counters and done pulse.
module loop_addr_gen #(
  parameter int unsigned M  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned IW = 8,
  parameter int unsigned AW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_i,
  input  logic [IW-1:0] in_j,
  input  logic [IW-1:0] in_k,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_c,
  output logic          out_last,
  output logic          done,
  output logic [CW-1:0] out_cnt,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

  localparam logic [AW-1:0] KA = AW'(K);
  localparam logic [AW-1:0] NA = AW'(N);

  logic          s1_v, s1_last, s1_kill;
  logic [AW-1:0] s1_ik, s1_kn, s1_in, s1_j, s1_k;
  logic          s2_v, s2_last, s2_kill;
  logic [AW-1:0] s2_a, s2_b, s2_c;

  logic in_kill, in_xfer, out_xfer, s2_retire, s1_adv;

  assign in_kill   = (32'(in_i) >= M) | (32'(in_j) >= N) | (32'(in_k) >= K);
  // killed entries drain from s2 on their own so they never block the pipe
  assign s2_retire = s2_v & (out_ready | s2_kill);
  assign s1_adv    = !s2_v | s2_retire;
  assign in_ready  = !s1_v | s1_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = s2_v & !s2_kill;
  assign out_xfer  = out_valid & out_ready;

  assign addr_a   = s2_a;
  assign addr_b   = s2_b;
  assign addr_c   = s2_c;
  assign out_last = s2_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_kill <= 1'b0;
      s1_ik   <= '0;
      s1_kn   <= '0;
      s1_in   <= '0;
      s1_j    <= '0;
      s1_k    <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_kill <= in_kill;
        s1_ik   <= AW'(in_i) * KA;
        s1_kn   <= AW'(in_k) * NA;
        s1_in   <= AW'(in_i) * NA;
        s1_j    <= AW'(in_j);
        s1_k    <= AW'(in_k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_kill <= 1'b0;
      s2_a    <= '0;
      s2_b    <= '0;
      s2_c    <= '0;
    end else if (s1_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_last <= s1_last;
        s2_kill <= s1_kill;
        s2_a    <= s1_ik + s1_k;
        s2_b    <= s1_kn + s1_j;
        s2_c    <= s1_in + s1_j;
      end
    end
  end

  // clr wins over a same-cycle event; counters stick at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= 1'b0;
      out_cnt <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= s2_retire & s2_last;
      if (clr) begin
        out_cnt <= '0;
        err     <= 1'b0;
        err_cnt <= '0;
      end else begin
        if (out_xfer && out_cnt != '1) out_cnt <= out_cnt + 1'b1;
        if (in_xfer && in_kill) begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_addr_gen.sv
// tb/tb_loop_addr_gen.sv - scoreboard bench for loop_addr_gen
module tb_loop_addr_gen;
  localparam int M = 4, N = 4, K = 4;

  logic        clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_i = '0, in_j = '0, in_k = '0;
  logic        in_ready, out_valid, out_last, done, err;
  logic [15:0] addr_a, addr_b, addr_c, out_cnt, err_cnt;

  loop_addr_gen dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_j(in_j), .in_k(in_k), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .addr_a(addr_a), .addr_b(addr_b),
    .addr_c(addr_c), .out_last(out_last), .done(done), .out_cnt(out_cnt),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, beats = 0, done_cnt = 0, mark = -1, first_cyc = 0, last_cyc = 0;
  int exp_errs = 0, ready_mode = 0, d0 = 0;
  bit exp_done = 0, prev_stall = 0;
  logic [15:0] pa, pb, pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // output monitor: pops the scoreboard on every out transfer
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
      exp_done = 0;
    end else begin
      if (exp_done) chk("done_after_last", done, 1);
      exp_done = 0;
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_a", addr_a, pa);
        chk("hold_b", addr_b, pb);
        chk("hold_c", addr_c, pc);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_beat", out_valid, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("addr_a", addr_a, e.a);
          chk("addr_b", addr_b, e.b);
          chk("addr_c", addr_c, e.c);
          chk("out_last", out_last, e.last);
          exp_done = e.last;
        end
        if (beats == mark) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      pa = addr_a; pb = addr_b; pc = addr_c;
    end
  end

  task automatic send(input int i, input int j, input int k, input bit last);
    exp_t e;
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; in_i = 8'(i); in_j = 8'(j); in_k = 8'(k); in_last = last;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("send_timeout", in_ready, 1);
    else if (i < M && j < N && k < K) begin
      e.a = 16'(i * K + k);
      e.b = 16'(k * N + j);
      e.c = 16'(i * N + j);
      e.last = last;
      sb.push_back(e);
    end else exp_errs++;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_a", addr_a, 0);

    // single tuple, two-cycle latency, one-cycle valid
    send(1, 2, 3, 0);
    idle();
    @(negedge clk);
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("single_a", addr_a, 7);
    chk("single_b", addr_b, 14);
    chk("single_c", addr_c, 6);
    @(negedge clk);
    chk("single_once", out_valid, 0);

    // full sweep at full rate
    pulse_clr();
    d0 = done_cnt;
    mark = beats;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++)
          send(i, j, k, (i == M-1) && (j == N-1) && (k == K-1));
    idle();
    drain();
    chk("sweep_out_cnt", out_cnt, 64);
    chk("sweep_done_once", done_cnt - d0, 1);
    chk("sweep_no_bubbles", last_cyc - first_cyc, 63);

    // backpressure: fill s1 and s2, hold, then release
    ready_mode = 1;
    repeat (2) @(negedge clk);
    send(2, 1, 0, 0);
    send(3, 0, 2, 0);
    idle();
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    chk("stall_valid", out_valid, 1);
    chk("stall_head_a", addr_a, sb[0].a);
    ready_mode = 0;
    drain();

    // killed last tuple
    pulse_clr();
    d0 = done_cnt;
    send(4, 0, 0, 1);
    idle();
    repeat (6) @(negedge clk);
    chk("kill_err", err, 1);
    chk("kill_err_cnt", err_cnt, 1);
    chk("kill_done", done_cnt - d0, 1);
    pulse_clr();
    chk("clr_err", err, 0);
    chk("clr_err_cnt", err_cnt, 0);

    // random stream with random backpressure and illegal indices
    exp_errs = 0;
    ready_mode = 2;
    for (int n = 0; n < 40; n++)
      send($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 0);
    idle();
    drain();
    ready_mode = 0;
    chk("rand_err_cnt", err_cnt, exp_errs);
    chk("rand_err", err, exp_errs != 0);

    // clr coinciding with an out transfer
    pulse_clr();
    send(1, 1, 1, 0);
    idle();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_xfer", out_cnt, 0);
    chk("clr_vs_xfer_sb", sb.size(), 0);

    // async reset with two entries in flight
    send(0, 1, 2, 0);
    send(2, 3, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_addr_a", addr_a, 0);
    chk("arst_addr_b", addr_b, 0);
    chk("arst_addr_c", addr_c, 0);
    chk("arst_out_cnt", out_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_stale", out_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
